// File: rtl/wb_write_queue_if.sv
// Write-back queue bus: producer handshakes, register-file write port,
// hazard-check lookups. master = datapath side, slave = the queue.
interface wb_write_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          ld_valid;
    logic          ld_ready;
    logic [4:0]    ld_rd;
    logic [31:0]   ld_data;
    logic          alu_valid;
    logic          alu_ready;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_data;
    logic          RegWr;
    logic [4:0]    RW;
    logic [31:0]   BusW;
    logic [4:0]    RA;
    logic [4:0]    RB;
    logic          pendA;
    logic          pendB;
    logic [31:0]   fwdA_data;
    logic [31:0]   fwdB_data;
    logic [CW-1:0] count;

    modport master (
        output ld_valid, ld_rd, ld_data,
        output alu_valid, alu_rd, alu_data,
        output RA, RB,
        input  ld_ready, alu_ready,
        input  RegWr, RW, BusW,
        input  pendA, pendB, fwdA_data, fwdB_data,
        input  count
    );

    modport slave (
        input  ld_valid, ld_rd, ld_data,
        input  alu_valid, alu_rd, alu_data,
        input  RA, RB,
        output ld_ready, alu_ready,
        output RegWr, RW, BusW,
        output pendA, pendB, fwdA_data, fwdB_data,
        output count
    );
endinterface

// File: rtl/wb_write_queue.sv
// In-order write-back FIFO feeding the register-file write port.
// Define WB_FWD_EN to enable youngest-pending-value forwarding on fwdA/fwdB.
module wb_write_queue #(
    parameter int DEPTH = 4
) (
    input logic           Clk,
    input logic           Rst,
    wb_write_queue_if.slave wb
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL = CW'(DEPTH - 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_ent_t;

    wb_ent_t       q [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          regwr;
    logic [4:0]    rw;
    logic [31:0]   busw;

    logic          ld_ok;
    logic          alu_ok;
    logic          ld_push;
    logic          alu_push;
    logic          pop;
    logic [AW-1:0] alu_slot;
    logic [CW-1:0] npush;
    logic [DEPTH-1:0] occ;
    logic [DEPTH-1:0] hit_a;
    logic [DEPTH-1:0] hit_b;

    // Readiness ignores a same-cycle pop so it never depends on valid.
    assign ld_ok    = !Rst && (cnt < FULL);
    assign alu_ok   = !Rst && (cnt < AFULL);
    assign ld_push  = wb.ld_valid && ld_ok && (wb.ld_rd != 5'd0);
    assign alu_push = wb.alu_valid && alu_ok && (wb.alu_rd != 5'd0);
    assign pop      = (cnt != '0);
    assign alu_slot = ld_push ? wp + AW'(1) : wp;
    assign npush    = CW'(ld_push) + CW'(alu_push);

    always_ff @(posedge Clk) begin
        if (ld_push)
            q[wp] <= '{rd: wb.ld_rd, data: wb.ld_data};
        if (alu_push)
            q[alu_slot] <= '{rd: wb.alu_rd, data: wb.alu_data};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            regwr <= 1'b0;
            rw    <= '0;
            busw  <= '0;
        end else begin
            wp  <= wp + AW'(npush);
            cnt <= cnt + npush - CW'(pop);
            if (pop) begin
                regwr <= 1'b1;
                rw    <= q[rp].rd;
                busw  <= q[rp].data;
                rp    <= rp + AW'(1);
            end else begin
                regwr <= 1'b0;
            end
        end
    end

    // A slot is live when its distance from the head is below the count.
    always_comb begin
        occ   = '0;
        hit_a = '0;
        hit_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i]   = ({1'b0, AW'(i) - rp} < cnt);
            hit_a[i] = occ[i] && (q[i].rd == wb.RA);
            hit_b[i] = occ[i] && (q[i].rd == wb.RB);
        end
    end

    assign wb.pendA = (wb.RA != 5'd0) &&
                      ((|hit_a) || (regwr && (rw == wb.RA)));
    assign wb.pendB = (wb.RB != 5'd0) &&
                      ((|hit_b) || (regwr && (rw == wb.RB)));

`ifdef WB_FWD_EN
    logic [31:0] fa;
    logic [31:0] fb;

    // Walk head to tail so the youngest queued match overrides older ones.
    always_comb begin
        logic [AW-1:0] idx;
        fa  = '0;
        fb  = '0;
        idx = rp;
        if (regwr && (rw == wb.RA))
            fa = busw;
        if (regwr && (rw == wb.RB))
            fb = busw;
        for (int j = 0; j < DEPTH; j++) begin
            idx = rp + AW'(j);
            if ((CW'(j) < cnt) && (q[idx].rd == wb.RA))
                fa = q[idx].data;
            if ((CW'(j) < cnt) && (q[idx].rd == wb.RB))
                fb = q[idx].data;
        end
        if (wb.RA == 5'd0)
            fa = '0;
        if (wb.RB == 5'd0)
            fb = '0;
    end

    assign wb.fwdA_data = fa;
    assign wb.fwdB_data = fb;
`else
    assign wb.fwdA_data = '0;
    assign wb.fwdB_data = '0;
`endif

    assign wb.ld_ready  = ld_ok;
    assign wb.alu_ready = alu_ok;
    assign wb.RegWr     = regwr;
    assign wb.RW        = rw;
    assign wb.BusW      = busw;
    assign wb.count     = cnt;
endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: queue-based reference model checked every cycle
// plus write-order scoreboards over directed and random traffic.
module tb_wb_write_queue;
    localparam int DEPTH = 4;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    wb_write_queue_if #(.DEPTH(DEPTH)) bus ();

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .wb  (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    ent_t        sb_exp[$];
    ent_t        sb_obs[$];
    logic        e_we = 1'b0;
    logic [4:0]  e_rw = '0;
    logic [31:0] e_bw = '0;
    int          total = 0;
    int          bad = 0;
    int          ncyc = 0;
    int          n_acc = 0;
    int          first_we = -1;
    int          last_we = -1;
    int          max_cnt = 0;
    bit          last_ld_acc;
    bit          last_alu_acc;
    logic [4:0]  ra = '0;
    logic [4:0]  rb = '0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pend_exp(logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
        return e_we && (e_rw == r);
    endfunction

    function automatic logic [31:0] fwd_exp(logic [4:0] r);
        if (r == 5'd0) return '0;
`ifdef WB_FWD_EN
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].rd == r) return mq[i].data;
        if (e_we && (e_rw == r)) return e_bw;
`endif
        return '0;
    endfunction

    task automatic check_outputs();
        bit lok;
        bit aok;
        lok = !Rst && (mq.size() < DEPTH);
        aok = !Rst && (mq.size() < DEPTH - 1);
        chk("ld_ready", 32'(bus.ld_ready), 32'(lok));
        chk("alu_ready", 32'(bus.alu_ready), 32'(aok));
        chk("count", 32'(bus.count), 32'(mq.size()));
        chk("RegWr", 32'(bus.RegWr), 32'(e_we));
        chk("RW", 32'(bus.RW), 32'(e_rw));
        chk("BusW", bus.BusW, e_bw);
        chk("pendA", 32'(bus.pendA), 32'(pend_exp(ra)));
        chk("pendB", 32'(bus.pendB), 32'(pend_exp(rb)));
        chk("fwdA", bus.fwdA_data, fwd_exp(ra));
        chk("fwdB", bus.fwdB_data, fwd_exp(rb));
        if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    endtask

    task automatic cyc(bit r, bit lv, logic [4:0] lrd, logic [31:0] ld,
                       bit av, logic [4:0] ard, logic [31:0] ad);
        ent_t e;
        bit   la;
        bit   aa;
        Rst           = r;
        bus.ld_valid  = lv;
        bus.ld_rd     = lrd;
        bus.ld_data   = ld;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.RA        = ra;
        bus.RB        = rb;
        #1;
        check_outputs();
        la = !r && lv && (mq.size() < DEPTH);
        aa = !r && av && (mq.size() < DEPTH - 1);
        @(posedge Clk);
        ncyc++;
        if (r) begin
            mq.delete();
            e_we = 1'b0;
            e_rw = '0;
            e_bw = '0;
        end else begin
            if (mq.size() > 0) begin
                e    = mq.pop_front();
                e_we = 1'b1;
                e_rw = e.rd;
                e_bw = e.data;
            end else begin
                e_we = 1'b0;
            end
            if (la && lrd != 5'd0) begin
                e.rd = lrd; e.data = ld;
                mq.push_back(e); sb_exp.push_back(e);
            end
            if (aa && ard != 5'd0) begin
                e.rd = ard; e.data = ad;
                mq.push_back(e); sb_exp.push_back(e);
            end
        end
        n_acc += int'(la) + int'(aa);
        last_ld_acc  = la;
        last_alu_acc = aa;
        #1;
        if (bus.RegWr === 1'b1) begin
            e.rd = bus.RW; e.data = bus.BusW;
            sb_obs.push_back(e);
            if (first_we < 0) first_we = ncyc;
            last_we = ncyc;
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, 0, '0, '0);
    endtask

    task automatic drain();
        int k = 0;
        while ((mq.size() > 0 || e_we) && k < 20) begin
            idle(1);
            k++;
        end
        idle(1);
        chk("drain_count", 32'(bus.count), 32'd0);
        chk("drain_regwr", 32'(bus.RegWr), 32'd0);
    endtask

    task automatic sb_clear();
        sb_exp.delete();
        sb_obs.delete();
        first_we = -1;
        last_we  = -1;
    endtask

    task automatic sb_check(string tag);
        chk({tag, "_nwrites"}, 32'(sb_obs.size()), 32'(sb_exp.size()));
        for (int i = 0; i < sb_exp.size() && i < sb_obs.size(); i++) begin
            chk({tag, "_rd"}, 32'(sb_obs[i].rd), 32'(sb_exp[i].rd));
            chk({tag, "_data"}, sb_obs[i].data, sb_exp[i].data);
        end
        sb_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0]  lrd, ard;
        logic [31:0] ldd, ad;
        int          k;

        bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_data = '0;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.RA = '0; bus.RB = '0;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        cyc(1, 0, '0, '0, 0, '0, '0);
        sb_clear();

        // single load into an empty queue
        ra = 5'd5; rb = 5'd0;
        cyc(0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
        idle(3);
        chk("t1_span", 32'(last_we - first_we + 1), 32'd1);
        sb_check("t1");

        // same rd from both producers in one cycle
        ra = 5'd3; rb = 5'd3;
        cyc(0, 1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
        idle(4);
        sb_check("t2");

        // rd == 0 is accepted but never queued
        ra = 5'd0; rb = 5'd0;
        cyc(0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'hFFFFFFFF);
        cyc(0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'hFFFFFFFF);
        idle(2);
        chk("t3_nwrites", 32'(sb_obs.size()), 32'd0);
        sb_clear();

        // back-to-back dual pushes until 20 results are accepted
        lrd = 5'($urandom_range(31, 1)); ldd = $urandom();
        ard = 5'($urandom_range(31, 1)); ad  = $urandom();
        n_acc = 0;
        k = 0;
        while (n_acc < 20 && k < 100) begin
            ra = lrd; rb = ard;
            cyc(0, 1, lrd, ldd, 1, ard, ad);
            if (last_ld_acc) begin
                lrd = 5'($urandom_range(31, 1)); ldd = $urandom();
            end
            if (last_alu_acc) begin
                ard = 5'($urandom_range(31, 1)); ad = $urandom();
            end
            k++;
        end
        chk("t4_accepted", 32'(n_acc >= 20), 32'd1);
        drain();
        sb_check("t4");

        // random traffic over a small register range
        for (int i = 0; i < 40; i++) begin
            ra = 5'($urandom_range(7, 0));
            rb = 5'($urandom_range(7, 0));
            cyc(0, 1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)),
                $urandom(),
                1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)),
                $urandom());
        end
        drain();
        sb_check("t5");

        // reset with three queued entries and a write on the port
        ra = 5'd9; rb = 5'd12;
        cyc(0, 1, 5'd9, 32'hA, 1, 5'd10, 32'hB);
        cyc(0, 1, 5'd11, 32'hC, 1, 5'd12, 32'hD);
        chk("t6_pre_count", 32'(bus.count), 32'd3);
        chk("t6_pre_regwr", 32'(bus.RegWr), 32'd1);
        cyc(1, 1, 5'd13, 32'hE, 1, 5'd14, 32'hF);
        sb_clear();
        cyc(0, 0, '0, '0, 0, '0, '0);
        chk("t6_post_regwr", 32'(bus.RegWr), 32'd0);
        idle(2);
        chk("t6_nwrites", 32'(sb_obs.size()), 32'd0);
        sb_clear();

        // continuous single pushes rd 1..31
        max_cnt = 0;
        ra = 5'd0; rb = 5'd0;
        for (int r = 1; r <= 31; r++) begin
            ra = 5'(r);
            cyc(0, 1, 5'(r), $urandom(), 0, '0, '0);
        end
        drain();
        chk("t7_nwrites", 32'(sb_obs.size()), 32'd31);
        chk("t7_span", 32'(last_we - first_we + 1), 32'd31);
        chk("t7_maxcnt", 32'(max_cnt <= 2), 32'd1);
        sb_check("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_write_queue.md
# wb_write_queue

Write-back queue that drives the register file's single write port (RW, BusW, RegWr) in the CPU datapath. It accepts completed results from two producers, the ALU path and the load path, with up to one of each per cycle. Results are buffered in an in-order FIFO and drained at one register write per clock. Per-register pending flags let the hazard logic stall readers whose source register still has a write in flight.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load result accepted when ld_valid && ld_ready.
- ld_rd  in  5  load destination register.
- ld_data  in  32  load result.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU handshake ready.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- RegWr  out  1  register-file write enable; registered.
- RW  out  5  register-file write address; registered.
- BusW  out  32  register-file write data; registered.
- RA, RB  in  5 each  read addresses to check against pending writes.
- pendA, pendB  out  1 each  a write to RA/RB is queued or being issued.
- fwdA_data, fwdB_data  out  32 each  youngest pending value for RA/RB (see Configuration).
- count  out  $clog2(DEPTH)+1  number of occupied FIFO entries.

## Operation
- FIFO with write pointer, read pointer and count.
  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- ld_ready = !Rst && count < DEPTH.
- alu_ready = !Rst && count < DEPTH-1.
  - Both flags are conservative: they ignore a pop in the same cycle and never depend on valid.
- Both producers accepted in one cycle: the load entry is enqueued first (older), the ALU entry second.
- An accepted result with rd == 0 completes its handshake but is not enqueued.
- Drain: at each posedge, if count > 0:
  - the head entry is loaded into RW/BusW;
  - RegWr is set to 1;
  - the read pointer advances.
- If count == 0 at the posedge, RegWr is set to 0; RW and BusW hold their values.
- Push and pop may occur in the same cycle; count' = count + pushes − pop.
- pendA = (RA != 0) && (RA matches any occupied entry, or RegWr && RW == RA). pendB is the same for RB.
  - Combinational from RA/RB and state.
- Same rd enqueued twice: both writes are issued in order, so the last write wins in the register file.
- Reset values: RegWr=0, RW=0, BusW=0, count=0, pointers=0, pendA=pendB=0, fwd*=0.
- Reset mid-operation discards all queued entries. No write is issued in the cycle after reset.

## Timing
- Enqueue at posedge k into an empty queue: RegWr=1 with that entry during the cycle after posedge k+1. Latency is two edges.
- Sustained throughput is one write per cycle. Two pushes per cycle fill the queue until alu_ready drops.
- pendA/pendB rise in the cycle after the enqueue edge.
  - They stay high until the cycle after the last matching write is presented on RegWr.
  - That is, they stay high while the register file captures the write at its posedge.
- The register file samples BusW/RW/RegWr at posedge. The queue's outputs change only at posedge.

## Configuration
- WB_FWD_EN defined:
  - fwdA_data/fwdB_data return the data of the youngest matching pending write.
  - Queued entries take precedence over the output stage; the tail side is youngest.
  - Hazard logic may then forward instead of stalling.
- WB_FWD_EN undefined:
  - fwdA_data/fwdB_data are tied to 0.
  - No comparison/priority-mux logic is synthesised.
  - pendA/pendB are unchanged.

## Test plan
- Single load, rd=5, data=0xDEADBEEF, pushed at edge 1 → RegWr=1, RW=5, BusW=0xDEADBEEF after edge 2 for exactly one cycle; pendA (RA=5) high from after edge 1 through after edge 2; low after edge 3.
- Simultaneous ld (rd=3, 0x11) and alu (rd=3, 0x22) → writes issued in order 0x11 then 0x22; with WB_FWD_EN, fwdA (RA=3) reads 0x22 while both are pending.
- rd=0 pushes (data 0xFFFFFFFF) from both producers → handshakes complete, count stays 0, RegWr stays 0, pendA(RA=0)=0.
- Back-to-back dual pushes with DEPTH=4 → alu_ready drops when count=3, ld_ready drops when count=4; no entry lost or duplicated over 20 random results, checked against a scoreboard.
- Rst asserted with count=3 and RegWr=1 → after that edge count=0, RegWr=0, RW=0, BusW=0, pend*=0; ld_ready/alu_ready low during Rst, high the next cycle.
- Continuous single pushes rd=1..31 → 31 consecutive RegWr cycles, RW incrementing 1..31, count never exceeds 2.
